spi_rx_capture: RTL and testbench

//  Receive path behind the SPI frame/clock generator. Watches that stage's sclk_n/cs_n

---
 rtl/spi_rx_capture_pkg.sv | 4 +
 rtl/spi_rx_capture_sync_fifo.sv | 40 ++++
 rtl/spi_rx_capture.sv | 115 +++++++++++
 tb/tb_spi_rx_capture.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_capture_pkg.sv
// Constants shared between the SPI frame/clock generator and its receive path.
package spi_rx_capture_pkg;
  localparam int PKG_SIZE = 8;
endpackage

// File: rtl/spi_rx_capture_sync_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][DW-1:0] mem;
  logic [AW:0]                   wr_ptr, rd_ptr;
  logic                          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/spi_rx_capture.sv
// SPI receive capture: aligns miso/sclk_n/cs_n, samples on sclk_n rise, assembles
// MSB-first words and queues them for the consumer; flags aborted frames and overruns.
module spi_rx_capture
  import spi_rx_capture_pkg::*;
#(
  parameter int DW          = PKG_SIZE,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk_n,
  input  logic          cs_n,
  input  logic          miso,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_ovr,
  output logic          busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam int         CW    = $clog2(DW+1);

  logic [SYNC_STAGES-1:0] miso_pipe, sclk_pipe, cs_pipe;
  logic                   d_miso, d_sclk_n, d_cs_n, d_sclk_n_q, rise;
  logic [1:0]             state, state_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [DW-1:0]          shreg;
  logic                   shift_en, cnt_clr, word_done_c, frame_err_c, word_done;
  logic                   fifo_full, fifo_empty, fifo_pop;

  // Reset clears the cs_n delay to 0 so a frame already running keeps the FSM in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_pipe  <= '0;
      sclk_pipe  <= '0;
      cs_pipe    <= '0;
      d_sclk_n_q <= 1'b0;
    end else begin
      miso_pipe  <= (miso_pipe << 1) | SYNC_STAGES'(miso);
      sclk_pipe  <= (sclk_pipe << 1) | SYNC_STAGES'(sclk_n);
      cs_pipe    <= (cs_pipe   << 1) | SYNC_STAGES'(cs_n);
      d_sclk_n_q <= d_sclk_n;
    end
  end

  assign d_miso   = miso_pipe[SYNC_STAGES-1];
  assign d_sclk_n = sclk_pipe[SYNC_STAGES-1];
  assign d_cs_n   = cs_pipe[SYNC_STAGES-1];
  assign rise     = d_sclk_n & ~d_sclk_n_q;

  always_ff @(posedge clk) begin
    if (rst) state <= HOLD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!d_cs_n) state_nxt = SHIFT;
      SHIFT:   if (d_cs_n) state_nxt = IDLE;
               else if (rise && bit_cnt == CW'(DW-1)) state_nxt = HOLD;
      HOLD:    if (d_cs_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cs_n deassertion wins over a coincident sclk_n rise
  always_comb begin
    cnt_clr     = (state == IDLE) & ~d_cs_n;
    shift_en    = (state == SHIFT) & ~d_cs_n & rise;
    word_done_c = shift_en & (bit_cnt == CW'(DW-1));
    frame_err_c = (state == SHIFT) & d_cs_n & (bit_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      word_done <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (cnt_clr) bit_cnt <= '0;
      else if (shift_en) begin
        bit_cnt <= bit_cnt + CW'(1);
        shreg   <= (shreg << 1) | DW'(d_miso);
      end
      word_done <= word_done_c;
      frame_err <= frame_err_c;
      busy      <= (state_nxt != IDLE);
      if (word_done && fifo_full && !fifo_pop) overrun <= 1'b1;
      else if (clr_ovr)                        overrun <= 1'b0;
    end
  end

  assign fifo_pop = rx_ready & ~fifo_empty;
  assign rx_valid = ~fifo_empty;

  sync_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done),
    .din   (shreg),
    .pop   (fifo_pop),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_spi_rx_capture.sv
// Directed bench for spi_rx_capture: table of single frames plus hand-written corner sequences.
module tb_spi_rx_capture;
  import spi_rx_capture_pkg::*;
  localparam int DW   = PKG_SIZE;
  localparam int SS   = 2;
  localparam int HALF = 3;

  logic          clk = 1'b0;
  logic          rst, sclk_n, cs_n, miso, rx_ready, clr_ovr;
  logic [DW-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;

  int   n_chk = 0, n_pass = 0, cyc = 0, rise_cyc = 0, valid_cyc = -1;
  int   err_cnt = 0, err0 = 0, pop_at = -100;
  logic prev_valid = 1'b0, arm_pop = 1'b0;

  typedef struct {
    logic [15:0] d;
    int          n;
    logic        exp_v;
    logic [7:0]  exp_d;
    int          exp_err;
  } vec_t;
  vec_t vt[9];

  spi_rx_capture #(.DW(DW), .FIFO_DEPTH(4), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk_n(sclk_n), .cs_n(cs_n), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid && !prev_valid) valid_cyc = cyc;
    prev_valid = rx_valid;
    if (frame_err) err_cnt++;
    if (cyc == pop_at) rx_ready = 1'b1;
    else if (cyc == pop_at + 1) rx_ready = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bits(input logic [15:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      miso   = d[n-1-k];
      sclk_n = 1'b0;
      ticks(HALF);
      sclk_n = 1'b1;
      if (k == DW-1) begin
        rise_cyc = cyc;
        if (arm_pop) pop_at = cyc + 3;
      end
      ticks(HALF);
    end
    sclk_n = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] d, input int n);
    cs_n = 1'b0;
    ticks(2);
    bits(d, n);
    ticks(HALF);
    cs_n = 1'b1;
    ticks(6);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, " valid"}, rx_valid, 1);
    check({name, " data"}, rx_data, exp);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{16'h0000, 8, 1'b1, 8'h00, 0};
    vt[1] = '{16'h00FF, 8, 1'b1, 8'hFF, 0};
    vt[2] = '{16'h0080, 8, 1'b1, 8'h80, 0};
    vt[3] = '{16'h0001, 8, 1'b1, 8'h01, 0};
    vt[4] = '{16'h005A, 8, 1'b1, 8'h5A, 0};
    vt[5] = '{16'h0005, 3, 1'b0, 8'h00, 1};
    vt[6] = '{16'h007F, 7, 1'b0, 8'h00, 1};
    vt[7] = '{16'h0001, 1, 1'b0, 8'h00, 1};
    vt[8] = '{16'h0000, 0, 1'b0, 8'h00, 0};

    rst = 1'b1; cs_n = 1'b0; sclk_n = 1'b0; miso = 1'b0; rx_ready = 1'b0; clr_ovr = 1'b0;
    ticks(3);
    check("rst rx_valid", rx_valid, 0);
    check("rst rx_data", rx_data, 0);
    check("rst frame_err", frame_err, 0);
    check("rst overrun", overrun, 0);
    check("rst busy", busy, 0);
    rst = 1'b0;
    err_cnt = 0;

    // 1: frame in progress at reset release is ignored; next frame captured with fixed latency
    bits(16'h00A5, 8);
    ticks(HALF);
    cs_n = 1'b1;
    ticks(6);
    check("t1 no word", rx_valid, 0);
    check("t1 no err", err_cnt, 0);
    valid_cyc = -1;
    send_frame(16'h003C, 8);
    check("t1 latency", valid_cyc - rise_cyc, SS + 2);
    pop_check("t1 3C", 8'h3C);
    check("t1 empty", rx_valid, 0);

    for (int i = 0; i < 9; i++) begin
      err0 = err_cnt;
      send_frame(vt[i].d, vt[i].n);
      check($sformatf("vec%0d valid", i), rx_valid, vt[i].exp_v);
      if (vt[i].exp_v) pop_check($sformatf("vec%0d", i), vt[i].exp_d);
      check($sformatf("vec%0d err", i), err_cnt - err0, vt[i].exp_err);
    end

    // 2: fill, overflow, drain in order, clear sticky overrun
    for (int i = 1; i <= 4; i++) send_frame(16'(i), 8);
    check("t2 valid", rx_valid, 1);
    check("t2 no ovr", overrun, 0);
    send_frame(16'h00FF, 8);
    check("t2 ovr", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("t2 pop%0d", i), 8'(i));
    check("t2 empty", rx_valid, 0);
    check("t2 ovr sticky", overrun, 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    tick();
    check("t2 ovr clr", overrun, 0);

    // 3: full FIFO, pop coincides with the push -> nothing lost
    for (int i = 0; i < 4; i++) send_frame(16'h0010 + 16'(i), 8);
    arm_pop = 1'b1;
    send_frame(16'h0055, 8);
    arm_pop = 1'b0;
    pop_at = -100;
    check("t3 no ovr", overrun, 0);
    pop_check("t3 pop11", 8'h11);
    pop_check("t3 pop12", 8'h12);
    pop_check("t3 pop13", 8'h13);
    pop_check("t3 pop55", 8'h55);
    check("t3 empty", rx_valid, 0);

    // 4: aborted frame then clean frame
    err0 = err_cnt;
    send_frame(16'h0016, 5);
    check("t4 err pulse", err_cnt - err0, 1);
    check("t4 no word", rx_valid, 0);
    send_frame(16'h0081, 8);
    pop_check("t4 81", 8'h81);
    check("t4 err once", err_cnt - err0, 1);

    // 5: extra sclk rises after a full word are ignored
    err0 = err_cnt;
    send_frame(16'b1100001110, 10);
    pop_check("t5 C3", 8'hC3);
    check("t5 single word", rx_valid, 0);
    check("t5 no err", err_cnt - err0, 0);

    // 6: reset mid-frame, released with cs_n low
    err0 = err_cnt;
    cs_n = 1'b0;
    ticks(2);
    bits(16'b010, 3);
    rst = 1'b1;
    ticks(2);
    check("t6 rst valid", rx_valid, 0);
    check("t6 rst err", frame_err, 0);
    rst = 1'b0;
    bits(16'b11010, 5);
    ticks(HALF);
    cs_n = 1'b1;
    ticks(6);
    check("t6 no word", rx_valid, 0);
    check("t6 no err", err_cnt - err0, 0);
    send_frame(16'h0096, 8);
    pop_check("t6 96", 8'h96);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
